mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Writeback stage of the pipelined processor, directly downstream of the memory stage. Contains the MEM/WB pipeline register with stall/flush control, the writeback source mux (ALU result, loaded data or return PC), register-file write-enable generation with `$zero` suppression, and a halt state machine that freezes retirement once a halt instruction reaches writeback. Its outputs drive the register-file write port and the forwarding unit.

## Interface
- `PC_BITS`, 32, width of the return PC; must be ≤ `PROC_BITS`
- `PROC_BITS`, 32, datapath width
- `REG_ADDRS_BITS`, 5, register-file address width
---
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  memory stage presents a real instruction
- `i_stall`  in  1  hold MEM/WB register contents
- `i_flush`  in  1  load a bubble instead of the input
- `i_alu_data`  in  `PROC_BITS`  ALU result
- `i_mem_data`  in  `PROC_BITS`  filtered load data; already registered by the data BRAM and valid during the WB cycle
- `i_rd`  in  `REG_ADDRS_BITS`  destination register
- `i_pc_to_reg`  in  1  write the return PC (link)
- `i_pc_return`  in  `PC_BITS`  return address
- `i_RegWrite`, `i_MemtoReg`, `i_halt`  in  1 each  control bits
- `o_wb_data`  out  `PROC_BITS`  register-file write data
- `o_wb_rd`  out  `REG_ADDRS_BITS`  register-file write address
- `o_wb_RegWrite`  out  1  register-file write enable
- `o_halted`  out  1  processor halted
- `o_retired`  out  32  retired-instruction count (`WB_RETIRE_COUNT_EN` only)

## Operation
- WB register fields: valid, alu_data, rd, pc_to_reg, pc_return, RegWrite, MemtoReg, halt.
- Update priority at each edge: `rst` > HALTED > `i_flush` > `i_stall` > load.
  - HALTED or flush: valid ← 0 and all control bits ← 0. Data fields are don't-care.
  - Stall: all fields hold.
  - Load: all fields ← inputs, and valid ← `i_valid`. When `i_valid`=0, control bits load as 0.
- `i_mem_data` is not registered here. It is used combinationally in the WB cycle. During a stall, the upstream stages hold the BRAM address, so the data stays stable.
- Writeback mux (combinational, from the WB register):
  - pc_to_reg=1: zero-extended pc_return. This takes priority over MemtoReg.
  - else MemtoReg=1: `i_mem_data`.
  - else: alu_data.
- `o_wb_RegWrite` = valid & RegWrite & (rd ≠ 0).
- `o_wb_rd` = rd.
- State machine, two states:
  - RUN → HALTED on the edge after a valid halt instruction is in the WB register and not stalled.
  - HALTED persists until `rst`.
  - `o_halted` = (state == HALTED).
  - The halt instruction's own RegWrite (if any) still takes effect.

## Timing
- Latency: inputs sampled at edge N appear on `o_wb_*` after edge N; the register-file write happens at edge N+1.
- Reset (async, immediate): all WB register fields 0, state RUN, `o_wb_data`=0, `o_wb_rd`=0, `o_wb_RegWrite`=0, `o_halted`=0, `o_retired`=0.
- Reset mid-stall or while HALTED fully clears the stage; the next edge after deassertion loads normally.
- Flush and stall together: flush wins, and a bubble is loaded.
- Stall in HALTED: has no effect.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - 32-bit `o_retired` increments on every edge where a valid WB instruction leaves WB, meaning it is not stalled and the state is RUN. The halt instruction counts.
  - Wraps 0xFFFFFFFF → 0.
  - Reset to 0.
- `WB_RETIRE_COUNT_EN` undefined: no counter logic, and `o_retired` is tied to 0.

## Test plan
- ALU op: alu_data=0x00001234, rd=3, RegWrite=1, valid=1 → next cycle `o_wb_data`=0x1234, `o_wb_rd`=3, `o_wb_RegWrite`=1; `o_retired`=1 one cycle later (counter build).
- Load: MemtoReg=1, rd=7; drive `i_mem_data`=0xDEADBEEF in the WB cycle → `o_wb_data`=0xDEADBEEF.
- Link priority: pc_to_reg=1, MemtoReg=1, pc_return=0x10, rd=31 → `o_wb_data`=0x00000010, `o_wb_RegWrite`=1.
- `$zero`: rd=0, RegWrite=1 → `o_wb_RegWrite`=0.
- Stall then flush:
  - Stall 3 cycles with rd=5 loaded → outputs held for 3 cycles and `o_retired` unchanged.
  - Flush together with stall → `o_wb_RegWrite`=0 the next cycle.
- Halt: valid halt then further valid RegWrite inputs →
  - `o_halted`=1 from the cycle after halt leaves WB.
  - No further `o_wb_RegWrite` and `o_retired` frozen.
  - Asserting `rst` asynchronously clears `o_halted` and `o_retired` to 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux, register-file write enable and halt FSM.
// Optional retired-instruction counter is enabled with `define WB_RETIRE_COUNT_EN.
module mem_wb_stage #(
    parameter int PC_BITS        = 32,
    parameter int PROC_BITS      = 32,
    parameter int REG_ADDRS_BITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [PROC_BITS-1:0]      i_alu_data,
    input  logic [PROC_BITS-1:0]      i_mem_data,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_pc_to_reg,
    input  logic [PC_BITS-1:0]        i_pc_return,
    input  logic                      i_RegWrite,
    input  logic                      i_MemtoReg,
    input  logic                      i_halt,
    output logic [PROC_BITS-1:0]      o_wb_data,
    output logic [REG_ADDRS_BITS-1:0] o_wb_rd,
    output logic                      o_wb_RegWrite,
    output logic                      o_halted,
    output logic [31:0]               o_retired
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t                    state_q, state_d;
    logic                      valid_q, valid_d;
    logic [PROC_BITS-1:0]      alu_data_q, alu_data_d;
    logic [REG_ADDRS_BITS-1:0] rd_q, rd_d;
    logic                      pc_to_reg_q, pc_to_reg_d;
    logic [PC_BITS-1:0]        pc_return_q, pc_return_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      halt_q, halt_d;
    logic                      halt_now;
    logic                      retire;

    // A halt leaving WB moves the FSM to HALTED and lets nothing younger in behind it.
    assign halt_now = (state_q == RUN) && valid_q && halt_q && !i_stall;
    assign retire   = (state_q == RUN) && valid_q && !i_stall;

    always_comb begin
        state_d      = halt_now ? HALTED : state_q;
        valid_d      = valid_q;
        alu_data_d   = alu_data_q;
        rd_d         = rd_q;
        pc_to_reg_d  = pc_to_reg_q;
        pc_return_d  = pc_return_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        halt_d       = halt_q;
        if (state_q == HALTED || halt_now || i_flush) begin
            valid_d      = 1'b0;
            pc_to_reg_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            halt_d       = 1'b0;
        end else if (!i_stall) begin
            valid_d      = i_valid;
            alu_data_d   = i_alu_data;
            rd_d         = i_rd;
            pc_return_d  = i_pc_return;
            pc_to_reg_d  = i_pc_to_reg & i_valid;
            reg_write_d  = i_RegWrite  & i_valid;
            mem_to_reg_d = i_MemtoReg  & i_valid;
            halt_d       = i_halt      & i_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            valid_q      <= 1'b0;
            alu_data_q   <= '0;
            rd_q         <= '0;
            pc_to_reg_q  <= 1'b0;
            pc_return_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            alu_data_q   <= alu_data_d;
            rd_q         <= rd_d;
            pc_to_reg_q  <= pc_to_reg_d;
            pc_return_q  <= pc_return_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            halt_q       <= halt_d;
        end
    end

    // Load data comes straight from the BRAM output register, so it is muxed unregistered.
    always_comb begin
        if (pc_to_reg_q)       o_wb_data = PROC_BITS'(pc_return_q);
        else if (mem_to_reg_q) o_wb_data = i_mem_data;
        else                   o_wb_data = alu_data_q;
    end

    assign o_wb_rd       = rd_q;
    assign o_wb_RegWrite = valid_q && reg_write_q && (rd_q != '0);
    assign o_halted      = (state_q == HALTED);

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q + 32'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign o_retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign o_retired     = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage; retire-count expectations follow WB_RETIRE_COUNT_EN.
module tb_mem_wb_stage;

`ifdef WB_RETIRE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_stall, i_flush;
    logic [31:0] i_alu_data, i_mem_data;
    logic [4:0]  i_rd;
    logic        i_pc_to_reg;
    logic [31:0] i_pc_return;
    logic        i_RegWrite, i_MemtoReg, i_halt;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_RegWrite, o_halted;
    logic [31:0] o_retired;

    int tests = 0;
    int fails = 0;

    mem_wb_stage #(.PC_BITS(32), .PROC_BITS(32), .REG_ADDRS_BITS(5)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .i_alu_data(i_alu_data), .i_mem_data(i_mem_data), .i_rd(i_rd),
        .i_pc_to_reg(i_pc_to_reg), .i_pc_return(i_pc_return), .i_RegWrite(i_RegWrite),
        .i_MemtoReg(i_MemtoReg), .i_halt(i_halt), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
        .o_wb_RegWrite(o_wb_RegWrite), .o_halted(o_halted), .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ret(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_stall = 0; i_flush = 0; i_alu_data = 0; i_mem_data = 0;
        i_rd = 0; i_pc_to_reg = 0; i_pc_return = 0; i_RegWrite = 0; i_MemtoReg = 0; i_halt = 0;
    endtask

    task automatic op(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                      input logic mtr, input logic link, input logic [31:0] pc, input logic hlt);
        i_valid = 1; i_alu_data = alu; i_rd = rd; i_RegWrite = rw; i_MemtoReg = mtr;
        i_pc_to_reg = link; i_pc_return = pc; i_halt = hlt;
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        chk("rst_data", o_wb_data, 0);
        chk("rst_rd", 32'(o_wb_rd), 0);
        chk("rst_we", 32'(o_wb_RegWrite), 0);
        chk("rst_halted", 32'(o_halted), 0);
        chk("rst_retired", o_retired, 0);
        #1 rst = 0;

        // ALU op
        op(32'h1234, 5'd3, 1, 0, 0, 0, 0);
        tick(); idle();
        chk("alu_data", o_wb_data, 32'h1234);
        chk("alu_rd", 32'(o_wb_rd), 3);
        chk("alu_we", 32'(o_wb_RegWrite), 1);
        tick();
        chk("alu_retired", o_retired, ret(1));

        // Load: mem data presented during the WB cycle
        op(32'h55, 5'd7, 1, 1, 0, 0, 0);
        tick(); idle(); i_mem_data = 32'hDEADBEEF;
        #1;
        chk("ld_data", o_wb_data, 32'hDEADBEEF);
        chk("ld_rd", 32'(o_wb_rd), 7);
        chk("ld_we", 32'(o_wb_RegWrite), 1);
        tick();
        chk("ld_retired", o_retired, ret(2));

        // Link beats MemtoReg
        op(32'h77, 5'd31, 1, 1, 1, 32'h10, 0);
        tick(); idle(); i_mem_data = 32'hCAFEF00D;
        #1;
        chk("link_data", o_wb_data, 32'h10);
        chk("link_rd", 32'(o_wb_rd), 31);
        chk("link_we", 32'(o_wb_RegWrite), 1);
        tick();

        // $zero suppression
        op(32'h99, 5'd0, 1, 0, 0, 0, 0);
        tick(); idle();
        chk("zero_we", 32'(o_wb_RegWrite), 0);
        chk("zero_data", o_wb_data, 32'h99);
        tick();
        chk("zero_retired", o_retired, ret(4));

        // Stall holds for three cycles, then flush+stall loads a bubble
        op(32'hAAAA, 5'd5, 1, 0, 0, 0, 0);
        tick();
        op(32'hBBBB, 5'd9, 1, 0, 0, 0, 0);
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_rd", 32'(o_wb_rd), 5);
            chk("stall_data", o_wb_data, 32'hAAAA);
            chk("stall_we", 32'(o_wb_RegWrite), 1);
            chk("stall_retired", o_retired, ret(4));
        end
        i_flush = 1;
        tick();
        chk("flush_we", 32'(o_wb_RegWrite), 0);
        chk("flush_retired", o_retired, ret(4));
        idle();

        // Halt followed by more writing instructions
        op(32'h22, 5'd2, 1, 0, 0, 0, 1);
        tick();
        op(32'h66, 5'd6, 1, 0, 0, 0, 0);
        chk("halt_we", 32'(o_wb_RegWrite), 1);
        chk("halt_rd", 32'(o_wb_rd), 2);
        chk("halt_pre", 32'(o_halted), 0);
        tick();
        chk("halted", 32'(o_halted), 1);
        chk("halted_we", 32'(o_wb_RegWrite), 0);
        chk("halted_retired", o_retired, ret(5));
        i_stall = 1;
        tick();
        i_stall = 0;
        tick();
        chk("halted_hold", 32'(o_halted), 1);
        chk("halted_we2", 32'(o_wb_RegWrite), 0);
        chk("halted_retired2", o_retired, ret(5));

        // Async reset from HALTED, then normal load
        #2 rst = 1;
        #1;
        chk("arst_halted", 32'(o_halted), 0);
        chk("arst_retired", o_retired, 0);
        chk("arst_data", o_wb_data, 0);
        rst = 0;
        op(32'h4321, 5'd8, 1, 0, 0, 0, 0);
        tick(); idle();
        chk("post_data", o_wb_data, 32'h4321);
        chk("post_we", 32'(o_wb_RegWrite), 1);
        tick();
        chk("post_retired", o_retired, ret(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
